// File: rtl/trng_pkg.sv
// -----------------------------------------------------------------------------
// trng_pkg
// Shared definitions for the ring-oscillator entropy sampler:
//   - sampler_state_t : FSM state encoding used by ro_entropy_sampler
//   - TRNG_*          : default parameter values and synchronizer depth
// No ports (package).
// -----------------------------------------------------------------------------
package trng_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WARMUP = 3'd1,
        S_SAMPLE = 3'd2,
        S_HOLD   = 3'd3,
        S_FAIL   = 3'd4
    } sampler_state_t;

    localparam int TRNG_NUM_RO        = 8;
    localparam int TRNG_WORD_W        = 32;
    localparam int TRNG_SAMPLE_DIV    = 16;
    localparam int TRNG_WARMUP_CYCLES = 64;
    localparam int TRNG_REP_LIMIT     = 32;
    localparam int TRNG_SYNC_STAGES   = 2;

endpackage

// File: rtl/ro_sync.sv
// -----------------------------------------------------------------------------
// ro_sync
// Single-bit synchronizer (TRNG_SYNC_STAGES flops) that brings one free-running
// ring-oscillator output into the clk domain.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous, active-high reset
//   d    in  asynchronous RO output
//   q    out synchronized bit
// -----------------------------------------------------------------------------
module ro_sync
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [TRNG_SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[TRNG_SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_ff[TRNG_SYNC_STAGES-1];

endmodule

// File: rtl/ro_entropy_sampler.sv
// -----------------------------------------------------------------------------
// ro_entropy_sampler
// Consumer side of the ring-oscillator entropy source. Enables the RO cells,
// synchronizes their outputs, XORs them into one raw bit per sample tick,
// runs a repetition-count health test on the raw bits and packs accepted bits
// into WORD_W-bit words delivered on a valid/ready stream.
//
// Optional build macro:
//   RO_VON_NEUMANN_EN  raw bits are debiased in pairs (01->0, 10->1, 00/11
//                      dropped); undefined: every raw bit is accepted.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   en           in   run request (level)
//   ro_in        in   [NUM_RO-1:0] asynchronous RO outputs
//   ro_en        out  enable to all RO cells
//   m_data       out  [WORD_W-1:0] random word
//   m_valid      out  m_data valid
//   m_ready      in   consumer accepts word
//   health_fail  out  sticky repetition-count failure
//   busy         out  FSM not in IDLE
//
// state  | meaning
// IDLE   | ROs off, waiting for en
// WARMUP | ROs on, letting them settle for WARMUP_CYCLES
// SAMPLE | ticking every SAMPLE_DIV cycles, shifting accepted bits in
// HOLD   | word presented on m_data/m_valid, tick counter frozen
// FAIL   | health test tripped, ROs off, waiting for en=0
// -----------------------------------------------------------------------------
module ro_entropy_sampler
    import trng_pkg::*;
#(
    parameter int NUM_RO        = TRNG_NUM_RO,
    parameter int WORD_W        = TRNG_WORD_W,
    parameter int SAMPLE_DIV    = TRNG_SAMPLE_DIV,
    parameter int WARMUP_CYCLES = TRNG_WARMUP_CYCLES,
    parameter int REP_LIMIT     = TRNG_REP_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_RO-1:0] ro_in,
    output logic              ro_en,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              health_fail,
    output logic              busy
);

    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int DIV_W  = $clog2(SAMPLE_DIV + 1);
    localparam int BIT_W  = $clog2(WORD_W + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);

    logic [NUM_RO-1:0] ro_s;
    logic              raw_bit;

    for (genvar i = 0; i < NUM_RO; i++) begin : g_sync
        ro_sync u_sync (
            .clk (clk),
            .rst (rst),
            .d   (ro_in[i]),
            .q   (ro_s[i])
        );
    end

    assign raw_bit = ^ro_s;

    sampler_state_t    state;
    logic [WARM_W-1:0] warm_cnt;
    logic [DIV_W-1:0]  tick_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic              prev_bit;
    logic [WORD_W-1:0] shift;
`ifdef RO_VON_NEUMANN_EN
    logic              pair_have;
    logic              pair_a;
`endif

    logic              tick;
    logic [REP_W-1:0]  rep_next;
    logic              rep_trip;
    logic              acc_valid;
    logic              acc_bit;
    logic [WORD_W-1:0] shift_next;
    logic              word_done;

    always_comb begin
        tick = (state == S_SAMPLE) && (tick_cnt == DIV_W'(SAMPLE_DIV - 1));
        // rep_cnt == 0 means no previous bit in this run yet
        if ((rep_cnt != '0) && (raw_bit == prev_bit)) begin
            rep_next = rep_cnt + REP_W'(1);
        end else begin
            rep_next = REP_W'(1);
        end
        rep_trip = (rep_next == REP_W'(REP_LIMIT));
`ifdef RO_VON_NEUMANN_EN
        // second bit of a differing pair yields the first bit of the pair
        acc_valid = tick && pair_have && (pair_a != raw_bit);
        acc_bit   = pair_a;
`else
        acc_valid = tick;
        acc_bit   = raw_bit;
`endif
        shift_next = {shift[WORD_W-2:0], acc_bit};
        word_done  = acc_valid && (bit_cnt == BIT_W'(WORD_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ro_en       <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            health_fail <= 1'b0;
            warm_cnt    <= '0;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            prev_bit    <= 1'b0;
            shift       <= '0;
`ifdef RO_VON_NEUMANN_EN
            pair_have   <= 1'b0;
            pair_a      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state    <= S_WARMUP;
                        ro_en    <= 1'b1;
                        warm_cnt <= WARM_W'(WARMUP_CYCLES - 1);
                        rep_cnt  <= '0;
                        bit_cnt  <= '0;
                        shift    <= '0;
                    end
                end

                S_WARMUP: begin
                    if (!en) begin
                        state <= S_IDLE;
                        ro_en <= 1'b0;
                    end else if (warm_cnt == '0) begin
                        state    <= S_SAMPLE;
                        tick_cnt <= '0;
`ifdef RO_VON_NEUMANN_EN
                        pair_have <= 1'b0;
`endif
                    end else begin
                        warm_cnt <= warm_cnt - WARM_W'(1);
                    end
                end

                S_SAMPLE: begin
                    if (!en) begin
                        // partial word is discarded
                        state   <= S_IDLE;
                        ro_en   <= 1'b0;
                        bit_cnt <= '0;
                        shift   <= '0;
                    end else if (tick) begin
                        tick_cnt <= '0;
                        prev_bit <= raw_bit;
                        rep_cnt  <= rep_next;
                        if (rep_trip) begin
                            // health failure wins over a word completing on the same tick
                            state       <= S_FAIL;
                            health_fail <= 1'b1;
                            ro_en       <= 1'b0;
                            m_valid     <= 1'b0;
                        end else begin
`ifdef RO_VON_NEUMANN_EN
                            pair_have <= ~pair_have;
                            if (!pair_have) begin
                                pair_a <= raw_bit;
                            end
`endif
                            if (acc_valid) begin
                                shift   <= shift_next;
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                if (word_done) begin
                                    m_data  <= shift_next;
                                    m_valid <= 1'b1;
                                    state   <= S_HOLD;
                                end
                            end
                        end
                    end else begin
                        tick_cnt <= tick_cnt + DIV_W'(1);
                    end
                end

                S_HOLD: begin
                    // en is only honoured once the pending word has been taken
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        bit_cnt <= '0;
                        shift   <= '0;
                        if (en) begin
                            state <= S_SAMPLE;
`ifdef RO_VON_NEUMANN_EN
                            pair_have <= 1'b0;
`endif
                        end else begin
                            state <= S_IDLE;
                            ro_en <= 1'b0;
                        end
                    end
                end

                S_FAIL: begin
                    if (!en) begin
                        health_fail <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    ro_en <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ro_entropy_sampler.sv
module tb_ro_entropy_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  ro_in;
    logic        ro_en;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        health_fail;
    logic        busy;

    ro_entropy_sampler dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ro_in       (ro_in),
        .ro_en       (ro_en),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .health_fail (health_fail),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic        seq[0:255];

    // Timing from the cycle P after which en is driven high:
    //   ro_en visible after P+1, SAMPLE entered at P+65,
    //   tick k at edge P+81+16k, 32nd bit -> m_valid after P+577.
    localparam int TICK0 = 81;
    localparam int DIV   = 16;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // scoreboard monitor: a word is consumed whenever valid && ready at the edge
    always @(negedge clk) begin
        if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h want none (cycle %0d)", m_data, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                check("word", m_data, mon_exp);
            end
        end
    end

    task automatic at_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en      = 1'b0;
        ro_in   = '0;
        m_ready = 1'b0;
        at_cyc(cyc + 5);
        rst = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) seq[i] = w[31-i];
    endtask

    // raw bit k is presented 8 cycles before tick k so it is settled through the synchronizer
    task automatic drive_seq(input int first_tick, input int n, input bit rnd);
        logic [7:0] r;
        for (int k = 0; k < n; k++) begin
            at_cyc(first_tick + DIV * k - 8);
            if (rnd) begin
                r = 8'($urandom_range(0, 255));
                if ((^r) != seq[k]) r[0] = ~r[0];
            end else begin
                r = {7'b0, seq[k]};
            end
            ro_in = r;
        end
    endtask

    int p;
    int h;

    initial begin
        // reset state
        do_reset();
        check("rst_ro_en", ro_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_health", health_fail, 0);
        check("rst_busy", busy, 0);

`ifndef RO_VON_NEUMANN_EN
        // random RO inputs with a known XOR per tick
        m_ready = 1'b1;
        load_word(32'h3C5A_96E1);
        exp_q.push_back(32'h3C5A_96E1);
        en = 1'b1;
        p  = cyc;
        check("t1_ro_en_before", ro_en, 0);
        at_cyc(p + 1);
        check("t1_ro_en_after", ro_en, 1);
        check("t1_busy", busy, 1);
        drive_seq(p + TICK0, 32, 1'b1);
        at_cyc(p + 576);
        check("t1_valid_early", m_valid, 0);
        at_cyc(p + 577);
        check("t1_valid_on_time", m_valid, 1);
        at_cyc(p + 580);
        do_reset();

        // ro_in[0] pattern, then 100 cycles of backpressure, then a second word
        load_word(32'hA5C3_0F96);
        exp_q.push_back(32'hA5C3_0F96);
        en = 1'b1;
        p  = cyc;
        drive_seq(p + TICK0, 32, 1'b0);
        at_cyc(p + 576);
        check("t2_valid_early", m_valid, 0);
        at_cyc(p + 577);
        check("t2_valid_on_time", m_valid, 1);
        for (int i = 1; i <= 100; i++) begin
            at_cyc(p + 577 + i);
            ro_in = 8'($urandom_range(0, 255));
            check("t3_hold_valid", m_valid, 1);
            check("t3_hold_data", m_data, 32'hA5C3_0F96);
        end
        load_word(32'h6B2D_4E71);
        exp_q.push_back(32'h6B2D_4E71);
        m_ready = 1'b1;
        h = cyc + 1;
        at_cyc(h);
        check("t3_valid_drop", m_valid, 0);
        drive_seq(h + DIV, 32, 1'b0);
        at_cyc(h + 511);
        check("t3_resume_early", m_valid, 0);
        at_cyc(h + 512);
        check("t3_resume_on_time", m_valid, 1);
        at_cyc(h + 515);
        do_reset();
`endif

        // stuck-at-0 ROs trip the repetition test on the 32nd tick
        m_ready = 1'b1;
        ro_in   = '0;
        en      = 1'b1;
        p       = cyc;
        at_cyc(p + 576);
        check("t4_health_early", health_fail, 0);
        at_cyc(p + 577);
        check("t4_health", health_fail, 1);
        check("t4_ro_en", ro_en, 0);
        check("t4_m_valid", m_valid, 0);
        check("t4_busy", busy, 1);
        en = 1'b0;
        at_cyc(p + 578);
        check("t4_health_clear", health_fail, 0);
        check("t4_idle", busy, 0);
        check("t4_ro_en_idle", ro_en, 0);
        do_reset();

`ifndef RO_VON_NEUMANN_EN
        // en dropped with 10 bits collected, then a clean word
        m_ready = 1'b1;
        load_word(32'hFFFF_0000);
        en = 1'b1;
        p  = cyc;
        drive_seq(p + TICK0, 10, 1'b1);
        at_cyc(p + 230);
        en = 1'b0;
        at_cyc(p + 231);
        check("t5_idle", busy, 0);
        check("t5_ro_en", ro_en, 0);
        at_cyc(p + 235);
        load_word(32'h1E87_C3B4);
        exp_q.push_back(32'h1E87_C3B4);
        en = 1'b1;
        p  = cyc;
        drive_seq(p + TICK0, 32, 1'b1);
        at_cyc(p + 576);
        check("t5_valid_early", m_valid, 0);
        at_cyc(p + 577);
        check("t5_valid_on_time", m_valid, 1);
        at_cyc(p + 580);
`else
        // Von Neumann: 01,10,11,00,10 gives 0,1,1; 29 more bits as (b,~b) pairs
        begin
            logic [9:0]  head;
            logic [28:0] tail;
            head = 10'b0110110010;
            tail = 29'h1234_5678;
            for (int i = 0; i < 10; i++) seq[i] = head[9-i];
            for (int i = 0; i < 29; i++) begin
                seq[10 + 2*i] = tail[28-i];
                seq[11 + 2*i] = ~tail[28-i];
            end
            exp_q.push_back({3'b011, tail});
        end
        m_ready = 1'b1;
        en = 1'b1;
        p  = cyc;
        drive_seq(p + TICK0, 68, 1'b1);
        at_cyc(p + TICK0 + DIV * 67 - 1);
        check("t6_valid_early", m_valid, 0);
        at_cyc(p + TICK0 + DIV * 67);
        check("t6_valid_on_time", m_valid, 1);
        at_cyc(cyc + 3);
`endif

        at_cyc(cyc + 5);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
